seg_disp_scroll: RTL and testbench

Downstream consumer of the key-control stage. It drives an 8-digit, common-anode, multiplexed seven-segment display from the key-control outputs: disp_data, weishu, shuzi and disp_data_en.
- In edit mode it shows the stored 8-digit number, with the live digit substituted at the selected position and blinking there.
- A rising edge on disp_data_en starts a one-shot scroll of the stored number across the display.

---
 rtl/seg_disp_scroll.sv | 142 ++++++++++++++
 tb/tb_seg_disp_scroll.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg_disp_scroll.sv
// 8-digit multiplexed seven-segment driver for the key-control stage:
// edit view with a blinking live digit, plus a one-shot scroll of a latched snapshot.
module seg_disp_scroll #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 12500000,
    parameter int SCROLL_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] disp_data,
    input  logic [3:0]  weishu,
    input  logic [3:0]  shuzi,
    input  logic        disp_data_en,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        scroll_busy
);
    localparam int SCW = ($clog2(SCAN_DIV)   < 1) ? 1 : $clog2(SCAN_DIV);
    localparam int BLW = ($clog2(BLINK_DIV)  < 1) ? 1 : $clog2(BLINK_DIV);
    localparam int SRW = ($clog2(SCROLL_DIV) < 1) ? 1 : $clog2(SCROLL_DIV);

    typedef enum logic {EDIT, SCROLL} state_t;

    state_t          state, state_nxt;
    logic [SCW-1:0]  scan_cnt;
    logic [2:0]      scan_idx;
    logic [BLW-1:0]  blink_cnt;
    logic            blink_ph;
    logic [SRW-1:0]  scroll_cnt, scroll_cnt_nxt;
    logic [3:0]      step, step_nxt;
    logic [31:0]     snapshot, snapshot_nxt;
    logic            busy_nxt;
    logic            en_d;
    logic            rise;
    logic [3:0]      nib;
    logic            blank;
    logic [4:0]      fidx;
    logic [7:0]      seg_nxt;

    assign rise = disp_data_en & ~en_d;

    function automatic logic [7:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 8'hC0;
            4'd1:    decode = 8'hF9;
            4'd2:    decode = 8'hA4;
            4'd3:    decode = 8'hB0;
            4'd4:    decode = 8'h99;
            4'd5:    decode = 8'h92;
            4'd6:    decode = 8'h82;
            4'd7:    decode = 8'hF8;
            4'd8:    decode = 8'h80;
            4'd9:    decode = 8'h90;
            default: decode = 8'hFF;
        endcase
    endfunction

    // A rising edge always wins, so a trigger mid-scroll restarts from step 0.
    always_comb begin
        state_nxt      = state;
        step_nxt       = step;
        scroll_cnt_nxt = scroll_cnt;
        snapshot_nxt   = snapshot;
        busy_nxt       = scroll_busy;
        if (rise) begin
            state_nxt      = SCROLL;
            step_nxt       = 4'd0;
            scroll_cnt_nxt = '0;
            snapshot_nxt   = disp_data;
            busy_nxt       = 1'b1;
        end else if (state == SCROLL) begin
            if (scroll_cnt == SRW'(SCROLL_DIV - 1)) begin
                scroll_cnt_nxt = '0;
                if (step == 4'd15) begin
                    state_nxt = EDIT;
                    busy_nxt  = 1'b0;
                end else begin
                    step_nxt = step + 4'd1;
                end
            end else begin
                scroll_cnt_nxt = scroll_cnt + SRW'(1);
            end
        end
    end

    // Frame index into {8 blanks, snapshot nibbles 7..0}; 8..15 map to nibble 15-fidx.
    always_comb begin
        nib   = 4'd0;
        blank = 1'b0;
        fidx  = 5'(step) + 5'(3'd7 - scan_idx);
        if (state == SCROLL) begin
            if (fidx >= 5'd8 && fidx <= 5'd15)
                nib = snapshot[{~fidx[2:0], 2'b00} +: 4];
            else
                blank = 1'b1;
        end else if (!weishu[3] && weishu[2:0] == scan_idx) begin
            nib   = shuzi;
            blank = blink_ph;
        end else begin
            nib = disp_data[{scan_idx, 2'b00} +: 4];
        end
        seg_nxt = blank ? 8'hFF : decode(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EDIT;
            scan_cnt    <= '0;
            scan_idx    <= 3'd0;
            blink_cnt   <= '0;
            blink_ph    <= 1'b0;
            scroll_cnt  <= '0;
            step        <= 4'd0;
            snapshot    <= 32'd0;
            scroll_busy <= 1'b0;
            en_d        <= 1'b0;
            an          <= 8'hFF;
            seg         <= 8'hFF;
        end else begin
            state       <= state_nxt;
            scroll_cnt  <= scroll_cnt_nxt;
            step        <= step_nxt;
            snapshot    <= snapshot_nxt;
            scroll_busy <= busy_nxt;
            en_d        <= disp_data_en;
            an          <= ~(8'd1 << scan_idx);
            seg         <= seg_nxt;
            if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCW'(1);
            end
            if (blink_cnt == BLW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BLW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seg_disp_scroll.sv
// Scoreboard bench for seg_disp_scroll: a time-based reference model predicts each
// cycle's an/seg/scroll_busy into a queue; a monitor pops and compares every cycle.
module tb_seg_disp_scroll;
    localparam int SCAN = 4;
    localparam int BLNK = 64;
    localparam int SCRL = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] disp_data = 32'h0;
    logic [3:0]  weishu = 4'd15;
    logic [3:0]  shuzi = 4'd0;
    logic        disp_data_en = 1'b0;
    logic [7:0]  an, seg;
    logic        scroll_busy;

    seg_disp_scroll #(.SCAN_DIV(SCAN), .BLINK_DIV(BLNK), .SCROLL_DIV(SCRL)) dut (
        .clk(clk), .rst_n(rst_n), .disp_data(disp_data), .weishu(weishu),
        .shuzi(shuzi), .disp_data_en(disp_data_en),
        .an(an), .seg(seg), .scroll_busy(scroll_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    logic [7:0] seg_tab [16];
    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: everything derived from edge counts since reset release
    // and the edge of the most recent scroll trigger.
    int          n_edge;
    int          t_trig;
    logic        en_prev;
    logic [31:0] snap;

    initial begin
        exp_t e;
        int m, p, stp, fi;
        logic [3:0] d;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                n_edge = 0; t_trig = -1; en_prev = 1'b0; snap = 32'h0;
                e.an = 8'hFF; e.seg = 8'hFF; e.busy = 1'b0;
            end else begin
                n_edge++;
                m = n_edge - 1;
                p = (m / SCAN) % 8;
                e.an = ~(8'd1 << p);
                if (t_trig >= 0 && (m - t_trig) < 16 * SCRL) begin
                    stp = (m - t_trig) / SCRL;
                    fi  = stp + 7 - p;
                    if (fi >= 8 && fi <= 15) begin
                        d = snap[(15 - fi) * 4 +: 4];
                        e.seg = seg_tab[d];
                    end else begin
                        e.seg = 8'hFF;
                    end
                end else if (weishu < 8 && int'(weishu) == p) begin
                    e.seg = (((m / BLNK) % 2) == 1) ? 8'hFF : seg_tab[shuzi];
                end else begin
                    d = disp_data[p * 4 +: 4];
                    e.seg = seg_tab[d];
                end
                if (disp_data_en && !en_prev) begin
                    t_trig = n_edge;
                    snap   = disp_data;
                end
                en_prev = disp_data_en;
                e.busy = (t_trig >= 0 && (n_edge - t_trig) < 16 * SCRL);
            end
            q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard at %0t: got empty queue expected an entry", $time);
            end else begin
                e = q.pop_front();
                chk("an", an, e.an);
                chk("seg", seg, e.seg);
                chk("scroll_busy", {7'd0, scroll_busy}, {7'd0, e.busy});
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic pulse_en();
        disp_data_en = 1'b1;
        tick(1);
        disp_data_en = 1'b0;
    endtask

    initial begin
        disp_data = 32'h12345678;
        weishu    = 4'd15;
        tick(3);
        rst_n = 1'b1;
        tick(80);                       // plain scan of 12345678

        disp_data = 32'h0; weishu = 4'd2; shuzi = 4'd9;
        tick(200);                      // blinking 9 at digit 2

        disp_data = 32'h7; weishu = 4'd8; shuzi = 4'd3;
        tick(100);                      // no selection, no blink

        disp_data = 32'h12345678; weishu = 4'd15;
        pulse_en();
        tick(16 * SCRL + 40);           // full scroll and return to EDIT

        pulse_en();
        tick(5 * SCRL);
        disp_data = 32'h0;              // ignored while scrolling
        tick(5 * SCRL);
        disp_data = 32'h12345678;
        pulse_en();                     // restart at step 10
        tick(16 * SCRL + 40);

        pulse_en();
        tick(7 * SCRL + 10);
        rst_n = 1'b0;
        #1;
        chk("reset_an", an, 8'hFF);
        chk("reset_seg", seg, 8'hFF);
        chk("reset_busy", {7'd0, scroll_busy}, 8'd0);
        tick(2);
        rst_n = 1'b1;
        tick(100);

        for (int i = 0; i < 30; i++) begin
            disp_data    = $urandom;
            weishu       = 4'($urandom_range(0, 15));
            shuzi        = 4'($urandom_range(0, 15));
            disp_data_en = ($urandom_range(0, 3) == 0);
            tick($urandom_range(1, 150));
        end
        disp_data_en = 1'b0;
        tick(16 * SCRL + 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
